// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'b00,
    ST_ARMED = 2'b01,
    ST_HIT   = 2'b10
  } state_t;

  function automatic int fill_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// Sample history shift register plus a saturating count of valid bits held.
module seq_hist_shift #(
  parameter int PAT_LEN = 4,
  parameter int FILL_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_clear,
  input  logic               i_data,
  output logic [PAT_LEN-1:0] o_hist,
  output logic [FILL_W-1:0]  o_fill
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

  logic [PAT_LEN-1:0] r_hist;
  logic [FILL_W-1:0]  r_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_en) begin
      r_hist <= {r_hist[PAT_LEN-2:0], i_data};
      if (r_fill != FILL_MAX) r_fill <= r_fill + 1'b1;
    end
  end

  assign o_hist = r_hist;
  assign o_fill = r_fill;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-loadable serial pattern detector with overlap mode and saturating match counter.
// Optional compare mask port is enabled by defining SEQDET_MASK_EN.
//
// state | meaning
// FILL  | fewer than PAT_LEN-1 valid bits held; no compare possible yet
// ARMED | next sample completes a window; compare against pattern
// HIT   | match pulse cycle; still samples like ARMED (overlap) or FILL
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN         = 4,
  parameter int                 CNT_W           = 8,
  parameter logic [PAT_LEN-1:0] DEFAULT_PAT     = PAT_LEN'(4'b1101),
  parameter logic               DEFAULT_OVERLAP = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic               i_data_in,
  input  logic               i_cfg_load,
  input  logic [PAT_LEN-1:0] i_cfg_pattern,
  input  logic               i_cfg_overlap,
`ifdef SEQDET_MASK_EN
  input  logic [PAT_LEN-1:0] i_cfg_mask,
`endif
  output logic               o_seq_detected,
  output logic [CNT_W-1:0]   o_match_count,
  output logic               o_count_sat
);

  localparam int FILL_W = fill_width(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_LEN - 1);
  localparam logic [FILL_W-1:0] FILL_PRE = FILL_W'(PAT_LEN - 2);

  logic [PAT_LEN-1:0] r_pat;
  logic               r_ovl;
  logic [PAT_LEN-1:0] w_mask;
  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_seq_det;
  logic [CNT_W-1:0]   r_count;

  logic               w_shift;
  logic               w_clear;
  logic               w_hit;
  logic [PAT_LEN-1:0] w_hist;
  logic [FILL_W-1:0]  w_fill;
  logic [PAT_LEN-1:0] w_cand;
  logic               w_eq;
  logic               w_full;
  logic               w_unused_hist_msb;

`ifdef SEQDET_MASK_EN
  logic [PAT_LEN-1:0] r_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_mask <= '1;
    else if (i_cfg_load) r_mask <= i_cfg_mask;
  end

  assign w_mask = r_mask;
`else
  assign w_mask = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat <= DEFAULT_PAT;
      r_ovl <= DEFAULT_OVERLAP;
    end else if (i_cfg_load) begin
      r_pat <= i_cfg_pattern;
      r_ovl <= i_cfg_overlap;
    end
  end

  seq_hist_shift #(
    .PAT_LEN (PAT_LEN),
    .FILL_W  (FILL_W)
  ) u_hist (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_shift),
    .i_clear (w_clear),
    .i_data  (i_data_in),
    .o_hist  (w_hist),
    .o_fill  (w_fill)
  );

  // The oldest history bit falls out of the window as the new sample enters.
  assign w_unused_hist_msb = w_hist[PAT_LEN-1];
  assign w_cand = {w_hist[PAT_LEN-2:0], i_data_in};
  assign w_eq   = ((w_cand ^ r_pat) & w_mask) == '0;
  assign w_full = (w_fill >= FILL_ARM);

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_clear     = 1'b0;
    w_hit       = 1'b0;
    if (i_cfg_load) begin
      w_clear     = 1'b1;
      w_state_nxt = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (i_en) begin
            w_shift = 1'b1;
            if (w_fill == FILL_PRE) w_state_nxt = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (i_en) begin
            if (w_eq) begin
              w_hit       = 1'b1;
              w_state_nxt = ST_HIT;
              w_shift     = r_ovl;
              w_clear     = !r_ovl;
            end else begin
              w_shift = 1'b1;
            end
          end
        end
        ST_HIT: begin
          // Window occupancy tells whether this cycle behaves as ARMED or FILL.
          w_state_nxt = w_full ? ST_ARMED : ST_FILL;
          if (i_en) begin
            if (w_full && w_eq) begin
              w_hit       = 1'b1;
              w_state_nxt = ST_HIT;
              w_shift     = r_ovl;
              w_clear     = !r_ovl;
            end else begin
              w_shift = 1'b1;
              if (!w_full && w_fill == FILL_PRE) w_state_nxt = ST_ARMED;
            end
          end
        end
        default: begin
          w_clear     = 1'b1;
          w_state_nxt = ST_FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FILL;
      r_seq_det <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_seq_det <= w_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_count <= '0;
    else if (i_cfg_load)         r_count <= '0;
    else if (w_hit && !(&r_count)) r_count <= r_count + 1'b1;
  end

  assign o_seq_detected = r_seq_det;
  assign o_match_count  = r_count;
  assign o_count_sat    = &r_count;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector table, hand sequences, and a random run vs a bit-queue model.
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_en, a_data, a_load, a_ovl;
  logic [3:0] a_pat;
  logic       a_det, a_sat;
  logic [7:0] a_cnt;

  logic       b_en, b_data, b_load, b_ovl;
  logic [1:0] b_pat;
  logic       b_det, b_sat;
  logic [1:0] b_cnt;

`ifdef SEQDET_MASK_EN
  logic [3:0] a_mask = 4'hF;
  logic [1:0] b_mask = 2'h3;
`endif

  seq_detector_param #(
    .PAT_LEN(4), .CNT_W(8), .DEFAULT_PAT(4'b1101), .DEFAULT_OVERLAP(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .i_en(a_en), .i_data_in(a_data),
    .i_cfg_load(a_load), .i_cfg_pattern(a_pat), .i_cfg_overlap(a_ovl),
`ifdef SEQDET_MASK_EN
    .i_cfg_mask(a_mask),
`endif
    .o_seq_detected(a_det), .o_match_count(a_cnt), .o_count_sat(a_sat)
  );

  seq_detector_param #(
    .PAT_LEN(2), .CNT_W(2), .DEFAULT_PAT(2'b11), .DEFAULT_OVERLAP(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_en(b_en), .i_data_in(b_data),
    .i_cfg_load(b_load), .i_cfg_pattern(b_pat), .i_cfg_overlap(b_ovl),
`ifdef SEQDET_MASK_EN
    .i_cfg_mask(b_mask),
`endif
    .o_seq_detected(b_det), .o_match_count(b_cnt), .o_count_sat(b_sat)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       en;
    logic       d;
    logic       load;
    logic [3:0] pat;
    logic       ovl;
    logic       det;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic en, input logic d, input logic load,
                              input logic [3:0] pat, input logic ovl,
                              input logic det, input logic [7:0] cnt);
    vec_t v;
    v.en = en; v.d = d; v.load = load; v.pat = pat; v.ovl = ovl; v.det = det; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  task automatic step_a(input logic en, input logic d, input logic load,
                        input logic [3:0] pat, input logic ovl);
    a_en = en; a_data = d; a_load = load; a_pat = pat; a_ovl = ovl;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of the valid bits since the last clear, newest at the back.
  logic [3:0] m_pat;
  logic       m_ovl;
  logic       m_det;
  int         m_cnt;
  bit         m_q[$];

  function automatic void model_reset();
    m_pat = 4'b1101; m_ovl = 1'b0; m_det = 1'b0; m_cnt = 0; m_q.delete();
  endfunction

  function automatic void model_step(input logic en, input logic d, input logic load,
                                     input logic [3:0] pat, input logic ovl);
    bit hit;
    m_det = 1'b0;
    if (load) begin
      m_pat = pat; m_ovl = ovl; m_cnt = 0; m_q.delete();
    end else if (en) begin
      m_q.push_back(d);
      if (m_q.size() > 4) void'(m_q.pop_front());
      hit = (m_q.size() == 4);
      for (int i = 0; i < 4; i++)
        if (m_q.size() == 4 && m_q[i] != m_pat[3-i]) hit = 1'b0;
      if (hit) begin
        m_det = 1'b1;
        if (m_cnt < 255) m_cnt++;
        if (!m_ovl) m_q.delete();
      end
    end
  endfunction

  initial begin
    logic [3:0] s1, s2;
    logic       en, d, ld, ov;
    logic [3:0] pt;

    rst_n = 1'b0;
    a_en = 0; a_data = 0; a_load = 0; a_pat = 0; a_ovl = 0;
    b_en = 0; b_data = 0; b_load = 0; b_pat = 0; b_ovl = 0;

    // defaults 1101 non-overlap
    s1 = 4'b1101;
    add(1,1,0,0,0, 0,0); add(1,1,0,0,0, 0,0); add(1,0,0,0,0, 0,0); add(1,1,0,0,0, 1,1);
    add(1,1,0,0,0, 0,1); add(1,0,0,0,0, 0,1); add(1,1,0,0,0, 0,1);
    // 1010 overlapping
    add(0,0,1,4'b1010,1, 0,0);
    add(1,1,0,0,0, 0,0); add(1,0,0,0,0, 0,0); add(1,1,0,0,0, 0,0);
    add(1,0,0,0,0, 1,1); add(1,1,0,0,0, 0,1); add(1,0,0,0,0, 1,2);
    // 1010 non-overlapping
    add(0,0,1,4'b1010,0, 0,0);
    add(1,1,0,0,0, 0,0); add(1,0,0,0,0, 0,0); add(1,1,0,0,0, 0,0);
    add(1,0,0,0,0, 1,1); add(1,1,0,0,0, 0,1); add(1,0,0,0,0, 0,1);
    // enable gap inside a partial match
    add(0,0,1,s1,0, 0,0);
    add(1,1,0,0,0, 0,0); add(1,1,0,0,0, 0,0);
    for (int i = 0; i < 5; i++) add(0,i[0],0,0,0, 0,0);
    add(1,0,0,0,0, 0,0); add(1,1,0,0,0, 1,1);
    // cfg_load mid-match discards the partial window and that cycle's bit
    add(1,1,0,0,0, 0,1); add(1,1,0,0,0, 0,1); add(1,0,0,0,0, 0,1);
    add(1,1,1,s1,0, 0,0);
    add(1,1,0,0,0, 0,0); add(1,1,0,0,0, 0,0); add(1,0,0,0,0, 0,0); add(1,1,0,0,0, 1,1);

    #3;
    check("reset_det", a_det, 0);
    check("reset_cnt", a_cnt, 0);
    check("reset_sat", a_sat, 0);
    check("reset_b_cnt", b_cnt, 0);
    #9 rst_n = 1'b1;

    foreach (tbl[i]) begin
      step_a(tbl[i].en, tbl[i].d, tbl[i].load, tbl[i].pat, tbl[i].ovl);
      check($sformatf("tbl%0d_det", i), a_det, tbl[i].det);
      check($sformatf("tbl%0d_cnt", i), a_cnt, tbl[i].cnt);
      check($sformatf("tbl%0d_sat", i), a_sat, 0);
    end

    // Async reset during HIT, with a non-default config that must revert.
    s2 = 4'b0110;
    step_a(0,0,1,s2,1);
    for (int i = 3; i >= 0; i--) step_a(1, s2[i], 0, 0, 0);
    check("hit_before_reset", a_det, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_det", a_det, 0);
    check("async_rst_cnt", a_cnt, 0);
    #2 rst_n = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      step_a(1, s1[i], 0, 0, 0);
      check($sformatf("revert_det%0d", i), a_det, (i == 0));
    end
    // Non-overlap must be back: 1,0,1 after the hit cannot complete a window.
    step_a(1,1,0,0,0); check("revert_novl_a", a_det, 0);
    step_a(1,0,0,0,0); check("revert_novl_b", a_det, 0);
    step_a(1,1,0,0,0); check("revert_novl_c", a_det, 0);
    check("revert_cnt", a_cnt, 1);
    a_en = 0;

    // Saturation on the 2-bit counter instance, pattern 11 overlapping.
    for (int i = 0; i < 6; i++) begin
      b_en = 1; b_data = 1;
      @(posedge clk); #1;
      check($sformatf("sat_det%0d", i), b_det, (i != 0));
      check($sformatf("sat_cnt%0d", i), b_cnt, (i == 0) ? 0 : ((i > 3) ? 3 : i));
      check($sformatf("sat_flag%0d", i), b_sat, (i >= 3));
    end
    b_en = 0;
    @(posedge clk); #1;
    check("sat_hold_cnt", b_cnt, 3);
    check("sat_drop_det", b_det, 0);

    // Random stream against the bit-queue model.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      ld = ($urandom_range(0, 59) == 0);
      pt = 4'($urandom_range(0, 15));
      ov = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom_range(0, 1));
      model_step(en, d, ld, pt, ov);
      step_a(en, d, ld, pt, ov);
      check("rand_det", a_det, m_det);
      check("rand_cnt", a_cnt, m_cnt);
      check("rand_sat", a_sat, (m_cnt == 255));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
